// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC sine engine.
// Holds the Q2.14 constants, default widths, the FSM state type and the
// output saturation helper used by cordic_sine_iter.
package cordic_pkg;

  // Q2.14 constants
  localparam int ANGLE_MAX = 25736;  // pi/2
  localparam int ONE_Q14   = 16384;  // 1.0
  localparam int KINV_Q14  = 9949;   // 1/1.64676, inverse CORDIC gain

  // Default geometry
  localparam int unsigned DEF_ITER  = 14;
  localparam int unsigned DEF_W     = 16;
  localparam int unsigned DEF_GUARD = 2;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StIter
  } state_e;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned      w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/cordic_rotate_step.sv
// Single rotation-mode CORDIC micro-rotation, purely combinational.
// Ports:
//   x, y       in   XW  current vector (two's complement)
//   z          in   ZW  residual angle (two's complement, Q2.14)
//   shift      in   4   iteration index i
//   atan_val   in   AW  atan(2^-i) in Q2.14
//   x_next, y_next, z_next  out  rotated vector and updated residual angle
module cordic_rotate_step #(
  parameter int unsigned XW = 18,
  parameter int unsigned ZW = 17,
  parameter int unsigned AW = 16
) (
  input  logic [XW-1:0] x,
  input  logic [XW-1:0] y,
  input  logic [ZW-1:0] z,
  input  logic [3:0]    shift,
  input  logic [AW-1:0] atan_val,
  output logic [XW-1:0] x_next,
  output logic [XW-1:0] y_next,
  output logic [ZW-1:0] z_next
);

  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;
  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic signed [ZW-1:0] zs;
  logic signed [ZW-1:0] atan_ext;

  always_comb begin
    xs       = $signed(x);
    ys       = $signed(y);
    zs       = $signed(z);
    atan_ext = ZW'($signed(atan_val));
    // Arithmetic shifts truncate toward minus infinity.
    x_sh     = xs >>> shift;
    y_sh     = ys >>> shift;
    // z >= 0 rotates counter-clockwise (d = +1).
    if (!zs[ZW-1]) begin
      x_next = xs - y_sh;
      y_next = ys + x_sh;
      z_next = zs - atan_ext;
    end else begin
      x_next = xs + y_sh;
      y_next = ys - x_sh;
      z_next = zs + atan_ext;
    end
  end

endmodule

// File: rtl/cordic_sine_iter.sv
// Iterative rotation-mode CORDIC sine/cosine engine, one micro-rotation per clock.
// The arctangent table sits outside and answers one cycle after lut_en/lut_idx.
// Build option: define CORDIC_GAIN_COMP_EN to seed x with 1/K so outputs are
// unit-amplitude; otherwise x starts at 1.0 and outputs carry the CORDIC gain.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, angle_in     request and Q2.14 angle (clamped to +-pi/2)
//   busy, done          in-progress flag, one-cycle completion pulse
//   sin_out, cos_out    Q2.14 results, held until the next done
//   range_err           angle was clamped, updated with done
//   lut_en, lut_idx     table read request
//   lut_data            table answer, valid the cycle after the request
module cordic_sine_iter
  import cordic_pkg::*;
#(
  parameter int unsigned ITER  = DEF_ITER,
  parameter int unsigned W     = DEF_W,
  parameter int unsigned GUARD = DEF_GUARD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] angle_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sin_out,
  output logic [W-1:0] cos_out,
  output logic         range_err,
  output logic         lut_en,
  output logic [3:0]   lut_idx,
  input  logic [W-1:0] lut_data
);

  localparam int unsigned XW = W + GUARD;
  localparam int unsigned ZW = W + 1;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int X_INIT = KINV_Q14;
`else
  localparam int X_INIT = ONE_Q14;
`endif

  state_e               state_q;
  state_e               state_d;
  logic signed [XW-1:0] x_q;
  logic signed [XW-1:0] y_q;
  logic signed [ZW-1:0] z_q;
  logic [3:0]           cnt_q;
  logic                 clamp_q;
  logic                 done_q;
  logic                 range_err_q;
  logic [W-1:0]         sin_q;
  logic [W-1:0]         cos_q;

  logic signed [W-1:0]  angle_s;
  logic signed [W-1:0]  angle_clamped;
  logic                 clamp_hit;
  logic                 last_iter;
  logic [XW-1:0]        x_nx;
  logic [XW-1:0]        y_nx;
  logic [ZW-1:0]        z_nx;
  logic [W-1:0]         sin_sat;
  logic [W-1:0]         cos_sat;

  // Input clamp to +-pi/2
  always_comb begin
    angle_s       = $signed(angle_in);
    angle_clamped = angle_s;
    clamp_hit     = 1'b0;
    if (int'(angle_s) > ANGLE_MAX) begin
      angle_clamped = W'(ANGLE_MAX);
      clamp_hit     = 1'b1;
    end else if (int'(angle_s) < -ANGLE_MAX) begin
      angle_clamped = W'(-ANGLE_MAX);
      clamp_hit     = 1'b1;
    end
  end

  assign last_iter = (state_q == StIter) && (cnt_q == 4'(ITER - 1));

  cordic_rotate_step #(
    .XW(XW),
    .ZW(ZW),
    .AW(W)
  ) u_step (
    .x        (x_q),
    .y        (y_q),
    .z        (z_q),
    .shift    (cnt_q),
    .atan_val (lut_data),
    .x_next   (x_nx),
    .y_next   (y_nx),
    .z_next   (z_nx)
  );

  always_comb begin
    sin_sat = W'(sat_signed(64'($signed(y_nx)), W));
    cos_sat = W'(sat_signed(64'($signed(x_nx)), W));
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StIter;
      StIter:  if (last_iter) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: the table is read one step ahead of the rotation that uses it.
  always_comb begin
    busy    = (state_q != StIdle);
    lut_en  = 1'b0;
    lut_idx = 4'd0;
    case (state_q)
      StLoad: begin
        lut_en  = 1'b1;
        lut_idx = 4'd0;
      end
      StIter: begin
        if (!last_iter) begin
          lut_en  = 1'b1;
          lut_idx = cnt_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      clamp_q     <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
      sin_q       <= '0;
      cos_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            x_q     <= XW'(X_INIT);
            y_q     <= '0;
            z_q     <= ZW'(angle_clamped);
            clamp_q <= clamp_hit;
            cnt_q   <= '0;
          end
        end
        StLoad: begin
          cnt_q <= '0;
        end
        StIter: begin
          x_q   <= $signed(x_nx);
          y_q   <= $signed(y_nx);
          z_q   <= $signed(z_nx);
          cnt_q <= cnt_q + 4'd1;
          if (last_iter) begin
            sin_q       <= sin_sat;
            cos_q       <= cos_sat;
            done_q      <= 1'b1;
            range_err_q <= clamp_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = done_q;
  assign sin_out   = sin_q;
  assign cos_out   = cos_q;
  assign range_err = range_err_q;

endmodule

// File: doc/cordic_sine_iter.md
Name: cordic_sine_iter

Overview:
- Iterative rotation-mode CORDIC engine for the sine generator; the direct consumer of the arctangent table stage.
- Accepts a Q2.14 angle and runs one micro-rotation per clock.
- Fetches atan(2^-i) from the table through a registered lookup port that has one cycle of latency.
- Returns sine and cosine in Q2.14 with a one-cycle done pulse.

Parameters:
- ITER, 14, number of micro-rotations; legal range 1..14, the depth of the table.
- W, 16, width of the angle, output and table data (Q2.14 signed).
- GUARD, 2, extra MSBs on the internal x/y datapath.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only while idle
- angle_in  in  W  signed Q2.14 angle in radians; legal range -25736..+25736 (±pi/2)
- busy  out  1  high while a computation is in progress
- done  out  1  one-cycle pulse; sin_out, cos_out and range_err are valid from this cycle
- sin_out  out  W  signed Q2.14 sine
- cos_out  out  W  signed Q2.14 cosine
- range_err  out  1  angle_in was outside the legal range and was clamped; updated on done
- lut_en  out  1  table read enable
- lut_idx  out  4  table index
- lut_data  in  W  signed table value; valid in the cycle after lut_en/lut_idx are presented

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state returns to IDLE;
  - busy, done, lut_en, range_err go to 0; sin_out, cos_out, lut_idx go to 0;
  - an operation in flight is aborted with no done pulse.
- State IDLE:
  - start=1 captures angle_in and moves to LOAD; busy rises on the next cycle.
  - Clamp on capture: values above 25736 become 25736, values below -25736 become -25736, and the clamp flag is latched.
  - Initial registers: z0 = clamped angle (sign-extended to W+1); y0 = 0; x0 = X_INIT, zero-extended to W+GUARD.
- State LOAD (1 cycle):
  - lut_en=1, lut_idx=0.
  - Next state ITER with i=0.
- State ITER (ITER cycles, i = 0..ITER-1):
  - lut_data holds atan(2^-i).
  - Direction d = +1 if z>=0, else -1.
  - Update: x <= x - d*(y>>>i); y <= y + d*(x>>>i); z <= z - d*lut_data.
  - Shifts are arithmetic, and the results are truncated.
  - If i < ITER-1: lut_en=1 and lut_idx=i+1 in the same cycle. Otherwise lut_en=0.
  - After i = ITER-1 the next state is IDLE.
- Completion:
  - On the edge that ends the last ITER cycle, sin_out and cos_out are registered from y and x, saturated to W-bit signed.
  - On that same edge, done is set for 1 cycle, range_err is updated from the latched flag, and busy falls.
- Latency:
  - With ITER=14, done is high exactly 16 cycles after the edge that sampled start.
  - In general the latency is ITER+2 cycles.
- Back-to-back operation:
  - start is honoured in the same cycle that done is high, because the state is already IDLE.
  - start during busy is ignored and not queued.
- Outputs hold their last values until the next done.
- lut_en is low whenever the state is IDLE.

Optional Feature:
- Macro CORDIC_GAIN_COMP_EN.
- Defined: X_INIT = 9949 (1/1.64676 in Q2.14). Outputs are unit-amplitude, so sin(pi/2) is about 16384.
- Undefined: X_INIT = 16384. Outputs carry the CORDIC gain, so sin(pi/2) is about 26981. GUARD=2 prevents internal overflow in this mode.

Decomposition:
- Package cordic_pkg:
  - Q-format constants: ANGLE_MAX=25736, ONE_Q14=16384, KINV_Q14=9949.
  - Default widths.
  - State enum: IDLE, LOAD, ITER.
  - Saturation function.
- Sub-module cordic_rotate_step: purely combinational single micro-rotation with inputs x, y, z, shift amount i and atan value, and outputs x', y', z'.
- The FSM, counter and registers stay in the top level.

Test Plan:
- Gain compensation on, angle_in=0, start pulse -> done at cycle 16 after start; sin_out in -4..4; cos_out = 16384±4; range_err=0.
- angle_in=12867 (pi/4) -> sin_out and cos_out both 11585±4. Also check the lut_idx sequence 0..13 on consecutive cycles with lut_en high for 14 cycles.
- angle_in=-8579 (-pi/6) -> sin_out=-8192±4, cos_out=14189±4. Then angle_in=25736 -> sin_out=16384±4, cos_out in -4..4.
- angle_in=30000 -> range_err=1 on done and sin_out=16384±4. A following run with angle_in=0 -> range_err=0.
- start held high continuously -> a new operation starts in each done cycle, done pulses every 16 cycles, and start during busy has no effect. Assert rst_n=0 at cycle 8 of a run -> no done, all outputs 0, busy=0.
- Gain compensation off, angle_in=25736 -> sin_out=26981±8, no saturation or wrap.
